// File: rtl/parking_pkg.sv
// parking_pkg: shared state encoding and default constants for the parking gate controller
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ENTER_PIN  = 3'd1,
        AUTHORIZED = 3'd2,
        BLOCKED    = 3'd3,
        PIN_ALARM  = 3'd4
    } state_t;

    localparam logic [7:0] PASSWORD     = 8'b0101_0111;
    localparam int         MAX_ATTEMPTS = 3;

endpackage

// File: rtl/parking_gate_controller_if.sv
// parking_gate_controller_if: sensor, keypad and gate/alarm signals between front end and controller
interface parking_gate_controller_if;

    logic       sensor_1;
    logic       sensor_2;
    logic [7:0] psswrd_atmpt;
    logic       try_psswrd;
    logic       open_gate;
    logic       close_gate;
    logic       alarm_1;
    logic       alarm_2;

    modport master (
        output sensor_1, sensor_2, psswrd_atmpt, try_psswrd,
        input  open_gate, close_gate, alarm_1, alarm_2
    );

    modport slave (
        input  sensor_1, sensor_2, psswrd_atmpt, try_psswrd,
        output open_gate, close_gate, alarm_1, alarm_2
    );

endinterface

// File: rtl/pin_checker.sv
// pin_checker: strobe edge detect, PIN comparison and saturating wrong-attempt counter
module pin_checker
    import parking_pkg::*;
#(
    parameter logic [7:0] PASS    = PASSWORD,
    parameter int         MAX_ATT = MAX_ATTEMPTS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       try_psswrd,
    input  logic [7:0] psswrd_atmpt,
    input  logic       count_en,
    input  logic       count_clr,
    output logic       attempt_ok,
    output logic       attempt_bad,
    output logic       count_reached
);

    localparam logic [2:0] MAX = 3'(MAX_ATT);

    logic       try_q;
    logic [2:0] cnt;
    logic       attempt;

    assign attempt       = try_psswrd & ~try_q;
    assign attempt_ok    = attempt & (psswrd_atmpt == PASS);
    assign attempt_bad   = attempt & (psswrd_atmpt != PASS);
    // true when one more wrong attempt lands the counter on MAX
    assign count_reached = cnt >= MAX - 3'd1;

    // strobe history and saturating counter; clear beats increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            try_q <= 1'b0;
            cnt   <= 3'd0;
        end else begin
            try_q <= try_psswrd;
            if (count_clr)
                cnt <= 3'd0;
            else if (count_en && cnt < MAX)
                cnt <= cnt + 3'd1;
        end
    end

endmodule

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: gate access FSM with registered gate and alarm outputs
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter logic [7:0] PASS    = PASSWORD,
    parameter int         MAX_ATT = MAX_ATTEMPTS
) (
    input  logic                       clk,
    input  logic                       rst,
    parking_gate_controller_if.slave   bus
);

    state_t state, state_nxt;
    logic   ok, bad, reached, count_en, count_clr, blk;
    logic   open_q, close_q, alarm1_q, alarm2_q;
    logic   open_nxt, close_nxt, alarm1_nxt, alarm2_nxt;

    pin_checker #(.PASS(PASS), .MAX_ATT(MAX_ATT)) u_pin (
        .clk           (clk),
        .rst           (rst),
        .try_psswrd    (bus.try_psswrd),
        .psswrd_atmpt  (bus.psswrd_atmpt),
        .count_en      (count_en),
        .count_clr     (count_clr),
        .attempt_ok    (ok),
        .attempt_bad   (bad),
        .count_reached (reached)
    );

    // a car on both sensors outside the alarm/blocked states overrides everything
    assign blk       = bus.sensor_1 & bus.sensor_2 & (state inside {IDLE, ENTER_PIN, AUTHORIZED});
    assign count_en  = (state == ENTER_PIN) & bad & ~blk;
    assign count_clr = ok & ~blk & (state inside {ENTER_PIN, PIN_ALARM, BLOCKED});

    // state and output registers commit together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            open_q   <= 1'b0;
            close_q  <= 1'b0;
            alarm1_q <= 1'b0;
            alarm2_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            open_q   <= open_nxt;
            close_q  <= close_nxt;
            alarm1_q <= alarm1_nxt;
            alarm2_q <= alarm2_nxt;
        end
    end

    // next-state selection
    always_comb begin
        state_nxt = state;
        if (blk)
            state_nxt = BLOCKED;
        else
            case (state)
                IDLE:       state_nxt = bus.sensor_1 ? ENTER_PIN : IDLE;
                ENTER_PIN:  state_nxt = ok                 ? AUTHORIZED :
                                        (bad && reached)   ? PIN_ALARM  :
                                        bad                ? ENTER_PIN  :
                                        !bus.sensor_1      ? IDLE       : ENTER_PIN;
                AUTHORIZED: state_nxt = (bus.sensor_2 && !bus.sensor_1) ? IDLE : AUTHORIZED;
                PIN_ALARM:  state_nxt = ok ? AUTHORIZED : PIN_ALARM;
                BLOCKED:    state_nxt = ok ? IDLE : BLOCKED;
                default:    state_nxt = IDLE;
            endcase
    end

    // outputs follow the state being entered; close also pulses on leaving AUTHORIZED
    always_comb begin
        open_nxt   = state_nxt == AUTHORIZED;
        alarm1_nxt = state_nxt == PIN_ALARM;
        alarm2_nxt = state_nxt == BLOCKED;
        close_nxt  = (state_nxt == BLOCKED) | (state == AUTHORIZED && state_nxt == IDLE);
    end

    assign bus.open_gate  = open_q;
    assign bus.close_gate = close_q;
    assign bus.alarm_1    = alarm1_q;
    assign bus.alarm_2    = alarm2_q;

endmodule
